// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-address generator: chip-enable levels,
// reset polarity and the FSM state encodings.
package pc_gen_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a taken branch that arrived while fetch was held.
// Capture wins over clear; reset is synchronous and active-low.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target,
    output logic              pend_vld,
    output logic [ADDR_W-1:0] pend_tgt
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pend_vld <= 1'b0;
            pend_tgt <= '0;
        end else if (capture) begin
            // A newer branch simply overwrites an older pending one.
            pend_vld <= 1'b1;
            pend_tgt <= target;
        end else if (clear) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: reset/idle/run FSM plus the flush > hold > branch >
// pending > increment next-pc priority mux feeding the instruction memory.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INC       = 4,
    parameter int                ALIGN_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              inst_rdy,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misalign
);

    logic [0:0]        state;
    logic              running;
    logic              hold;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_tgt;
    logic              buf_capture;
    logic              buf_clear;
    logic [ADDR_W-1:0] pc_nxt;

    assign running = (state == S_RUN);
    assign hold    = stall | ~inst_rdy;

    // Flush discards anything pending; any un-held run edge consumes or drops it.
    assign buf_capture = running & ~flush & hold & branch_flag;
    assign buf_clear   = running & (flush | ~hold);

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .capture  (buf_capture),
        .clear    (buf_clear),
        .target   (branch_target),
        .pend_vld (pend_vld),
        .pend_tgt (pend_tgt)
    );

    always_comb begin
        pc_nxt = pc + ADDR_W'(INC);
        if (flush) begin
            pc_nxt = new_pc;
        end else if (hold) begin
            pc_nxt = pc;
        end else if (branch_flag) begin
            pc_nxt = branch_target;
        end else if (pend_vld) begin
            pc_nxt = pend_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ce    <= CHIP_DISABLE;
            pc    <= RESET_VEC;
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    ce    <= CHIP_ENABLE;
                    pc    <= RESET_VEC;
                    state <= S_RUN;
                end
                default: begin
                    ce <= CHIP_ENABLE;
                    pc <= pc_nxt;
                end
            endcase
        end
    end

    generate
        if (ALIGN_LSB > 0) begin : g_align
            assign pc_misalign = ce & (|pc[ALIGN_LSB-1:0]);
        end else begin : g_no_align
            assign pc_misalign = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (reset vector 0 and FFFFFFF8) share stimulus;
// a per-instance reference model is compared every cycle, plus literal spot checks.
module tb_pc_gen;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        inst_rdy = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] pc_a, pc_b;
    logic        ce_a, ce_b, mis_a, mis_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_VEC(RV_A), .INC(4), .ALIGN_LSB(2)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .inst_rdy(inst_rdy), .flush(flush),
        .new_pc(new_pc), .branch_flag(branch_flag), .branch_target(branch_target),
        .pc(pc_a), .ce(ce_a), .pc_misalign(mis_a)
    );

    pc_gen #(.ADDR_W(32), .RESET_VEC(RV_B), .INC(4), .ALIGN_LSB(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .inst_rdy(inst_rdy), .flush(flush),
        .new_pc(new_pc), .branch_flag(branch_flag), .branch_target(branch_target),
        .pc(pc_b), .ce(ce_b), .pc_misalign(mis_b)
    );

    // Reference model: fetch state seen from outside (enabled?, address, buffered branch).
    typedef struct packed {
        logic        seen_reset;
        logic        fetching;
        logic [31:0] addr;
        logic        has_pending;
        logic [31:0] pending;
    } mdl_t;

    mdl_t m_a = '0;
    mdl_t m_b = '0;

    function automatic mdl_t model_step(input mdl_t m, input logic [31:0] rv);
        mdl_t n = m;
        if (!rst) begin
            n.seen_reset  = 1'b1;
            n.fetching    = 1'b0;
            n.addr        = rv;
            n.has_pending = 1'b0;
        end else if (!m.fetching) begin
            n.fetching = 1'b1;
            n.addr     = rv;
        end else if (flush) begin
            n.addr        = new_pc;
            n.has_pending = 1'b0;
        end else if (stall || !inst_rdy) begin
            if (branch_flag) begin
                n.has_pending = 1'b1;
                n.pending     = branch_target;
            end
        end else if (branch_flag) begin
            n.addr        = branch_target;
            n.has_pending = 1'b0;
        end else if (m.has_pending) begin
            n.addr        = m.pending;
            n.has_pending = 1'b0;
        end else begin
            n.addr = 32'((64'(m.addr) + 64'd4) % 64'h1_0000_0000);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a <= model_step(m_a, RV_A);
        m_b <= model_step(m_b, RV_B);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model once reset has been observed.
    always @(negedge clk) begin
        if (m_a.seen_reset) begin
            check("model_a_ce", 32'(ce_a), 32'(m_a.fetching));
            check("model_a_pc", pc_a, m_a.addr);
            check("model_a_mis", 32'(mis_a), 32'(m_a.fetching && (m_a.addr % 4 != 0)));
            check("model_b_ce", 32'(ce_b), 32'(m_b.fetching));
            check("model_b_pc", pc_b, m_b.addr);
            check("model_b_mis", 32'(mis_b), 32'(m_b.fetching && (m_b.addr % 4 != 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // 1: reset sequence and first increments (plus wrap on instance b)
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ce", 32'(ce_a), 32'd0);
            check("rst_pc", pc_a, 32'h0);
        end
        rst = 1'b1;
        tick();
        check("t1_ce", 32'(ce_a), 32'd1);
        check("t1_pc0", pc_a, 32'h0);
        check("t5_pc0", pc_b, 32'hFFFF_FFF8);
        tick();
        check("t1_pc4", pc_a, 32'h4);
        check("t5_pc1", pc_b, 32'hFFFF_FFFC);
        tick();
        check("t1_pc8", pc_a, 32'h8);
        check("t5_wrap", pc_b, 32'h0);
        tick();
        check("t1_pcc", pc_a, 32'hC);
        tick();
        check("t1_pc10", pc_a, 32'h10);

        // 2: two-cycle stall, resume with no bubble
        stall = 1'b1;
        tick(); check("t2_hold1", pc_a, 32'h10);
        tick(); check("t2_hold2", pc_a, 32'h10);
        stall = 1'b0;
        tick(); check("t2_resume", pc_a, 32'h14);

        // 3: branch arrives while memory not ready, applied on release
        flush = 1'b1; new_pc = 32'h10;
        tick(); check("t3_flush", pc_a, 32'h10);
        flush = 1'b0; inst_rdy = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        tick(); check("t3_held", pc_a, 32'h10);
        inst_rdy = 1'b1; branch_flag = 1'b0;
        tick(); check("t3_pend", pc_a, 32'h100);
        tick(); check("t3_next", pc_a, 32'h104);

        // 4: flush beats stall and a simultaneous branch; pending branch dropped
        stall = 1'b1; flush = 1'b1; new_pc = 32'h20; branch_flag = 1'b1; branch_target = 32'h300;
        tick(); check("t4_flush", pc_a, 32'h20);
        flush = 1'b0; branch_flag = 1'b0;
        tick(); check("t4_hold", pc_a, 32'h20);
        stall = 1'b0;
        tick(); check("t4_resume", pc_a, 32'h24);

        // 5: unaligned branch target is flagged, not corrected
        branch_flag = 1'b1; branch_target = 32'h102;
        tick();
        check("t5_br_pc", pc_a, 32'h102);
        check("t5_mis", 32'(mis_a), 32'd1);
        branch_flag = 1'b0;
        tick();
        check("t5_mis_inc", pc_a, 32'h106);

        // 6: reset with a pending branch discards it
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h400;
        tick();
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0;
        tick();
        check("t6_ce", 32'(ce_a), 32'd0);
        check("t6_pc", pc_b, 32'hFFFF_FFF8);
        rst = 1'b1;
        tick(); check("t6_restart", pc_a, 32'h0);
        tick(); check("t6_no_pend", pc_a, 32'h4);

        // Randomised traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) != 0);
            stall         = ($urandom_range(0, 4) == 0);
            inst_rdy      = ($urandom_range(0, 6) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            branch_flag   = ($urandom_range(0, 5) == 0);
            new_pc        = $urandom() & ~32'h3;
            branch_target = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & ~32'h3);
            if ($urandom_range(0, 15) == 0) branch_target = 32'hFFFF_FFF0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
